// File: rtl/sid_pkg.sv
// Shared types and byte-protocol constants for the SID register-write stream engine.
//   sid_state_e : parser state encoding
//   sid_hdr_t   : decoded write-header payload (chip select index + register)
//   decode_hdr  : splits a header byte into its fields
package sid_pkg;

    localparam int unsigned CHIP_W      = 2;
    localparam int unsigned REG_W       = 5;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned OP_WAIT_BIT = 7;
    localparam int unsigned CHIP_LSB    = 5;
    localparam int unsigned CHIP_MSB    = 6;

    localparam logic [BYTE_W-1:0] OP_NOP = 8'hFF;

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_DATA  = 2'd1,
        ST_WRITE = 2'd2,
        ST_WAIT  = 2'd3
    } sid_state_e;

    typedef struct packed {
        logic [CHIP_W-1:0] chip;
        logic [REG_W-1:0]  addr;
    } sid_hdr_t;

    function automatic sid_hdr_t decode_hdr(input logic [BYTE_W-1:0] b);
        sid_hdr_t h;
        h.chip = b[CHIP_MSB:CHIP_LSB];
        h.addr = b[REG_W-1:0];
        return h;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO with registered level and registered not-full flag.
//   slowclk, n_reset : clock, async active-low reset
//   push, push_data  : write strobe/byte (ignored while not_full is low)
//   pop              : consume head byte (ignored while empty)
//   head_c, empty_c  : current head byte and empty flag (combinational)
//   not_full         : registered space-available flag
//   level            : registered byte count
//   level_nxt_c      : byte count after the current edge
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     slowclk,
    input  logic                     n_reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head_c,
    output logic                     empty_c,
    output logic                     not_full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_nxt_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             not_full_q, not_full_d;
    logic             do_push, do_pop;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push    = push && not_full_q;
        do_pop     = pop && (level_q != '0);
        wr_ptr_d   = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(do_pop);
        level_d    = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        // Derived from the next level so a full FIFO never sees an extra push.
        not_full_d = (level_d != LVL_W'(DEPTH));
    end

    always_ff @(posedge slowclk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            not_full_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            not_full_q <= not_full_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge slowclk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_c      = mem_q[rd_ptr_q];
    assign empty_c     = (level_q == '0);
    assign not_full    = not_full_q;
    assign level       = level_q;
    assign level_nxt_c = level_d;

endmodule

// File: rtl/sid_stream_player.sv
// SID register-write stream engine: buffers a byte stream, decodes write/wait/no-op
// commands and issues at most one chip-select strobe per clk_en period.
//   slowclk, n_reset   : clock, async active-low reset
//   clk_en             : one-cycle SID tick strobe
//   s_tdata/s_tvalid/s_tready : byte input handshake
//   sid_addr, sid_data : register address/data for the selected chip
//   sid_n_cs           : active-low chip selects (at most one low)
//   busy               : bytes pending or command in progress
//   bad_chip           : pulse on a header naming a missing chip
//   fifo_level         : bytes held in the input FIFO
module sid_stream_player
    import sid_pkg::*;
#(
    parameter int unsigned N_SID      = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned WAIT_UNIT  = 1000
) (
    input  logic                          slowclk,
    input  logic                          n_reset,
    input  logic                          clk_en,
    input  logic [7:0]                    s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    output logic [4:0]                    sid_addr,
    output logic [7:0]                    sid_data,
    output logic [N_SID-1:0]              sid_n_cs,
    output logic                          busy,
    output logic                          bad_chip,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WAIT_MAX = 128 * WAIT_UNIT;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

    logic [BYTE_W-1:0] head_c;
    logic              empty_c;
    logic              pop_c;
    logic              push_c;
    logic [LVL_W-1:0]  level_nxt_c;
    sid_hdr_t          hdr_c;
    logic              hdr_bad_c;

    sid_state_e        state_q, state_d;
    logic [CHIP_W-1:0] chip_q, chip_d;
    logic [REG_W-1:0]  reg_q, reg_d;
    logic              drop_q, drop_d;
    logic              cs_on_q, cs_on_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [REG_W-1:0]  addr_q, addr_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic [N_SID-1:0]  n_cs_q, n_cs_d;
    logic              bad_q, bad_d;
    logic              busy_q, busy_d;

    assign push_c = s_tvalid && s_tready;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .slowclk     (slowclk),
        .n_reset     (n_reset),
        .push        (push_c),
        .push_data   (s_tdata),
        .pop         (pop_c),
        .head_c      (head_c),
        .empty_c     (empty_c),
        .not_full    (s_tready),
        .level       (fifo_level),
        .level_nxt_c (level_nxt_c)
    );

    assign hdr_c     = decode_hdr(head_c);
    assign hdr_bad_c = ({1'b0, hdr_c.chip} >= 3'(N_SID));

    // Command parser: next state, chip-select strobe and wait countdown.
    always_comb begin
        state_d = state_q;
        chip_d  = chip_q;
        reg_d   = reg_q;
        drop_d  = drop_q;
        cs_on_d = cs_on_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        data_d  = data_q;
        n_cs_d  = n_cs_q;
        bad_d   = 1'b0;
        pop_c   = 1'b0;

        unique case (state_q)
            ST_HDR: begin
                if (!empty_c) begin
                    pop_c = 1'b1;
                    if (head_c == OP_NOP) begin
                        state_d = ST_HDR;
                    end else if (head_c[OP_WAIT_BIT]) begin
                        wait_d  = (WAIT_W'(head_c[6:0]) + WAIT_W'(1)) * WAIT_W'(WAIT_UNIT);
                        state_d = ST_WAIT;
                    end else begin
                        chip_d  = hdr_c.chip;
                        reg_d   = hdr_c.addr;
                        drop_d  = hdr_bad_c;
                        bad_d   = hdr_bad_c;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (!empty_c) begin
                    pop_c  = 1'b1;
                    drop_d = 1'b0;
                    if (drop_q) begin
                        // Data byte of an unaddressable chip is discarded.
                        state_d = ST_HDR;
                    end else begin
                        addr_d  = reg_q;
                        data_d  = head_c;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // Select goes low one cycle after entry and is released after the
                // first cycle it spends low with clk_en set.
                if (!cs_on_q) begin
                    cs_on_d = 1'b1;
                    n_cs_d  = ~(N_SID'(1) << chip_q);
                end else if (clk_en) begin
                    cs_on_d = 1'b0;
                    n_cs_d  = '1;
                    state_d = ST_HDR;
                end
            end
            ST_WAIT: begin
                if (clk_en) begin
                    wait_d = wait_q - WAIT_W'(1);
                    if (wait_q == WAIT_W'(1)) begin
                        state_d = ST_HDR;
                    end
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase

        busy_d = (level_nxt_c != '0) || (state_d != ST_HDR);
    end

    always_ff @(posedge slowclk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_HDR;
            chip_q  <= '0;
            reg_q   <= '0;
            drop_q  <= 1'b0;
            cs_on_q <= 1'b0;
            wait_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            n_cs_q  <= '1;
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chip_q  <= chip_d;
            reg_q   <= reg_d;
            drop_q  <= drop_d;
            cs_on_q <= cs_on_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            n_cs_q  <= n_cs_d;
            bad_q   <= bad_d;
            busy_q  <= busy_d;
        end
    end

    assign sid_addr = addr_q;
    assign sid_data = data_q;
    assign sid_n_cs = n_cs_q;
    assign bad_chip = bad_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sid_stream_player.sv
// Directed bench for sid_stream_player (N_SID=2, FIFO_DEPTH=4, WAIT_UNIT=4, clk_en every 4 cycles).
module tb_sid_stream_player;

    logic       slowclk;
    logic       n_reset;
    logic       clk_en;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;
    logic [4:0] sid_addr;
    logic [7:0] sid_data;
    logic [1:0] sid_n_cs;
    logic       busy;
    logic       bad_chip;
    logic [2:0] fifo_level;

    sid_stream_player #(
        .N_SID      (2),
        .FIFO_DEPTH (4),
        .WAIT_UNIT  (4)
    ) dut (
        .slowclk    (slowclk),
        .n_reset    (n_reset),
        .clk_en     (clk_en),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .sid_addr   (sid_addr),
        .sid_data   (sid_data),
        .sid_n_cs   (sid_n_cs),
        .busy       (busy),
        .bad_chip   (bad_chip),
        .fifo_level (fifo_level)
    );

    typedef struct {
        int         chip;
        logic [4:0] addr;
        logic [7:0] data;
        int         ticks;
        bit         last_en;
        int         end_tick;
    } wrec_t;

    typedef struct {
        logic [7:0] hdr;
        logic [7:0] dat;
        bit         exp_write;
        int         exp_chip;
        logic [4:0] exp_addr;
        int         exp_bad;
    } vec_t;

    int    tests = 0;
    int    fails = 0;
    int    tick_cnt = 0;
    int    bad_cnt = 0;
    int    multi_low = 0;
    int    cyc = 0;
    wrec_t wq[$];
    wrec_t cur;
    bit    in_w = 0;

    initial slowclk = 1'b0;
    always #5 slowclk = ~slowclk;

    // clk_en high in every fourth cycle, changed just after the rising edge.
    initial begin
        clk_en = 1'b0;
        forever begin
            @(posedge slowclk);
            #1;
            cyc++;
            clk_en = ((cyc % 4) == 3);
        end
    end

    // Write/strobe monitor sampled on the falling edge.
    always @(negedge slowclk) begin
        if (!n_reset) begin
            in_w = 0;
        end else begin
            int ci;
            ci = -1;
            for (int i = 0; i < 2; i++) if (!sid_n_cs[i]) ci = i;
            if (sid_n_cs == 2'b00) multi_low++;
            if (clk_en) tick_cnt++;
            if (bad_chip) bad_cnt++;
            if (ci >= 0) begin
                if (!in_w) begin
                    in_w       = 1;
                    cur.chip   = ci;
                    cur.addr   = sid_addr;
                    cur.data   = sid_data;
                    cur.ticks  = 0;
                end
                if (clk_en) cur.ticks++;
                cur.last_en  = clk_en;
                cur.end_tick = tick_cnt;
            end else if (in_w) begin
                in_w = 0;
                wq.push_back(cur);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int budget);
        bit acc;
        acc      = 0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge slowclk);
            acc = s_tready;
            @(posedge slowclk);
            #1;
            if (acc) break;
        end
        s_tvalid = 1'b0;
        if (!acc) chk($sformatf("send_accept_%02h", b), 32'(acc), 32'd1);
    endtask

    task automatic wait_write(output wrec_t r, output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            if (wq.size() > 0) begin
                r  = wq.pop_front();
                ok = 1;
                break;
            end
            @(posedge slowclk);
            #1;
        end
        chk("write_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int i = 0; i < 600; i++) begin
            if (!busy && sid_n_cs == 2'b11 && !in_w) begin
                idle = 1;
                break;
            end
            @(posedge slowclk);
            #1;
        end
        chk("idle_reached", 32'(idle), 32'd1);
    endtask

    task automatic chk_write(input string tag, input wrec_t r, input int chip,
                             input logic [4:0] addr, input logic [7:0] data);
        chk({tag, "_chip"}, 32'(r.chip), 32'(chip));
        chk({tag, "_addr"}, 32'(r.addr), 32'(addr));
        chk({tag, "_data"}, 32'(r.data), 32'(data));
        chk({tag, "_ticks_in_low"}, 32'(r.ticks), 32'd1);
        chk({tag, "_release_after_en"}, 32'(r.last_en), 32'd1);
    endtask

    initial begin
        vec_t  vecs[7];
        wrec_t r, r2;
        bit    ok;
        int    b0, base, hi_cnt;

        vecs[0] = '{8'h18, 8'h0F, 1'b1, 0, 5'h18, 0};
        vecs[1] = '{8'h21, 8'hAA, 1'b1, 1, 5'h01, 0};
        vecs[2] = '{8'h01, 8'h55, 1'b1, 0, 5'h01, 0};
        vecs[3] = '{8'h3F, 8'hFF, 1'b1, 1, 5'h1F, 0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 0, 5'h00, 0};
        vecs[5] = '{8'h40, 8'h99, 1'b0, 0, 5'h00, 1};
        vecs[6] = '{8'h7F, 8'h12, 1'b0, 0, 5'h00, 1};

        n_reset  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
        repeat (2) @(posedge slowclk);
        #1;
        chk("rst_n_cs", 32'(sid_n_cs), 32'h3);
        chk("rst_addr", 32'(sid_addr), 32'h0);
        chk("rst_data", 32'(sid_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_bad", 32'(bad_chip), 32'h0);
        chk("rst_ready", 32'(s_tready), 32'h1);
        chk("rst_level", 32'(fifo_level), 32'h0);
        @(posedge slowclk);
        #3;
        n_reset = 1'b1;
        @(posedge slowclk);
        #1;

        // Table: one header/data pair per entry.
        for (int i = 0; i < 7; i++) begin
            b0 = bad_cnt;
            send(vecs[i].hdr, 50);
            send(vecs[i].dat, 50);
            if (vecs[i].exp_write) begin
                wait_write(r, ok);
                if (ok) chk_write($sformatf("v%0d", i), r, vecs[i].exp_chip,
                                  vecs[i].exp_addr, vecs[i].dat);
            end
            wait_idle();
            chk($sformatf("v%0d_bad_pulses", i), 32'(bad_cnt - b0), 32'(vecs[i].exp_bad));
            chk($sformatf("v%0d_no_extra_write", i), 32'(wq.size()), 32'd0);
        end

        // Back-to-back writes land on consecutive clk_en ticks.
        send(8'h21, 50);
        send(8'hAA, 50);
        send(8'h01, 50);
        send(8'h55, 50);
        wait_write(r, ok);
        if (ok) chk_write("b2b_first", r, 1, 5'h01, 8'hAA);
        wait_write(r2, ok);
        if (ok) begin
            chk_write("b2b_second", r2, 0, 5'h01, 8'h55);
            chk("b2b_tick_spacing", 32'(r2.end_tick - r.end_tick), 32'd1);
        end
        wait_idle();

        // Wait of 3 units = 12 ticks, then a write needing one more tick.
        for (int i = 0; i < 20; i++) begin
            @(negedge slowclk);
            if (clk_en) break;
        end
        @(posedge slowclk);
        #1;
        base = tick_cnt;
        send(8'h82, 50);
        send(8'h00, 50);
        send(8'h11, 50);
        wait_write(r, ok);
        if (ok) begin
            chk_write("wait_write", r, 0, 5'h00, 8'h11);
            chk("wait_tick_count", 32'(r.end_tick - base), 32'd13);
        end
        wait_idle();

        // Bad chip, dropped data, no-op, then a good write.
        b0 = bad_cnt;
        send(8'h40, 50);
        send(8'h99, 50);
        send(8'hFF, 50);
        send(8'h05, 50);
        send(8'h01, 50);
        wait_write(r, ok);
        if (ok) chk_write("mix", r, 0, 5'h05, 8'h01);
        wait_idle();
        chk("mix_bad_pulses", 32'(bad_cnt - b0), 32'd1);
        chk("mix_single_write", 32'(wq.size()), 32'd0);

        // Back-pressure while parked in a long wait.
        send(8'h8F, 50);
        send(8'h18, 50);
        send(8'h0F, 50);
        send(8'h21, 50);
        send(8'h44, 50);
        chk("full_ready", 32'(s_tready), 32'd0);
        chk("full_level", 32'(fifo_level), 32'd4);
        s_tdata  = 8'h02;
        s_tvalid = 1'b1;
        hi_cnt   = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge slowclk);
            if (s_tready) hi_cnt++;
        end
        @(posedge slowclk);
        #1;
        chk("full_ready_held_low", 32'(hi_cnt), 32'd0);
        chk("full_level_held", 32'(fifo_level), 32'd4);
        send(8'h02, 600);
        send(8'h77, 100);
        wait_write(r, ok);
        if (ok) chk_write("bp_w0", r, 0, 5'h18, 8'h0F);
        wait_write(r, ok);
        if (ok) chk_write("bp_w1", r, 1, 5'h01, 8'h44);
        wait_write(r, ok);
        if (ok) chk_write("bp_w2", r, 0, 5'h02, 8'h77);
        wait_idle();
        chk("bp_no_extra_write", 32'(wq.size()), 32'd0);

        // Reset in the middle of a write strobe.
        send(8'h18, 50);
        send(8'h0F, 50);
        send(8'h01, 50);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (sid_n_cs != 2'b11) begin
                ok = 1;
                break;
            end
            @(posedge slowclk);
            #1;
        end
        chk("midwrite_cs_low", 32'(ok), 32'd1);
        #2;
        n_reset = 1'b0;
        #1;
        chk("midrst_n_cs", 32'(sid_n_cs), 32'h3);
        chk("midrst_level", 32'(fifo_level), 32'h0);
        chk("midrst_ready", 32'(s_tready), 32'h1);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_addr", 32'(sid_addr), 32'h0);
        @(posedge slowclk);
        #3;
        n_reset = 1'b1;
        @(posedge slowclk);
        #1;
        wq.delete();
        send(8'h01, 50);
        send(8'h66, 50);
        wait_write(r, ok);
        if (ok) chk_write("post_rst", r, 0, 5'h01, 8'h66);
        wait_idle();
        chk("post_rst_single_write", 32'(wq.size()), 32'd0);

        chk("never_two_cs_low", 32'(multi_low), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
